tick_arbiter: RTL and testbench
===============================

TICK_ARBITER -- requirements
Module: tick_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of tick sources sharing the pipeline (2..8).
REQ-002 Parameter MAX_INFLIGHT, default 8, maximum samples issued to the pipeline but not yet returned (power of 2, 2..32).
REQ-003 Derived widths: IDW = $clog2(NUM_SRC); CW = $clog2(MAX_INFLIGHT)+1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 src_valid  in  NUM_SRC  per-source sample valid.
REQ-007 src_ready  out  NUM_SRC  per-source accept; only the granted bit may be 1.
REQ-008 src_data  in  NUM_SRC x 32  per-source signed Q16.16 samples.
REQ-009 pipe_in_valid / pipe_in_ready / pipe_in_data  out/in/out  1/1/32  issue port to the feature/signal/risk pipeline input.
REQ-010 pipe_out_valid / pipe_out_ready / pipe_out_data  in/out/in  1/1/32  pipeline output return port.
REQ-011 res_valid / res_ready / res_data / res_id  out/in/out/out  1/1/32/IDW  tagged result stream.
REQ-012 drain_req  in  1  level request to stop issuing and empty the pipeline.
REQ-013 drain_done  out  1  pipeline empty and issue halted.
REQ-014 inflight  out  CW  samples currently outstanding.
REQ-015 tag_err  out  1  sticky: result returned with no outstanding tag.

Function
REQ-016 Handshake on every port: transfer when valid && ready on a rising edge; valid, once asserted, holds with stable data until transfer.
REQ-017 Round-robin arbitration: search starts at index last+1 (mod NUM_SRC), first src_valid wins; last updates to the winner only on pipe_in transfer.
REQ-018 Grant lock: once pipe_in_valid asserts, grant index and pipe_in_data stay frozen until pipe_in transfer, regardless of other src_valid changes.
REQ-019 pipe_in_valid = src_valid[grant] && issue_en; pipe_in_data = src_data[grant]; src_ready[grant] = pipe_in_ready && issue_en; all others 0; zero added latency.
REQ-020 issue_en = (state==RUN || lock held) && inflight < MAX_INFLIGHT; a new grant starts only in RUN.
REQ-021 Tag FIFO, depth MAX_INFLIGHT: push grant index on pipe_in transfer; pop on res transfer; order preserved (pipeline is in-order).
REQ-022 res_valid = pipe_out_valid && tag FIFO non-empty; res_data = pipe_out_data; res_id = FIFO head; pipe_out_ready = res_ready when non-empty.
REQ-023 pipe_out_valid with FIFO empty: pipe_out_ready=1 (sample dropped), res_valid=0, tag_err set until reset.
REQ-024 inflight: +1 on issue, -1 on result, unchanged on simultaneous issue and result; never exceeds MAX_INFLIGHT or drops below 0.
REQ-025 At inflight==MAX_INFLIGHT no issue occurs that cycle; a same-cycle result does not enable issue until the next cycle.
REQ-026 FSM states RUN, DRAIN, HALTED: RUN->DRAIN when drain_req=1; DRAIN->HALTED when inflight==0 and no lock held; HALTED->RUN when drain_req=0; DRAIN->RUN if drain_req drops before empty.
REQ-027 drain_done = 1 exactly in HALTED (registered state decode).
REQ-028 Locked pending issue at drain_req rise completes normally; no further grants until RUN.
REQ-029 Data passes unmodified; no arithmetic on sample values.

Reset
REQ-030 rst_n low: state=RUN, last=NUM_SRC-1, lock cleared, FIFO empty, inflight=0, tag_err=0, drain_done=0; hence src_ready=0, pipe_in_valid=0, res_valid=0 until rst_n high.
REQ-031 Reset mid-operation discards all outstanding tags; results arriving after reset are handled per REQ-023.

Verification
REQ-032 All 4 sources valid, pipe_in_ready=1, res_ready=1 -> issue order 0,1,2,3,0...; res_id matches issue order; inflight settles at pipeline depth.
REQ-033 src0 valid with 0x0001_8000, pipe_in_ready=0 for 5 cycles while src2 asserts -> pipe_in_data stays 0x0001_8000, src_ready[2]=0; grant moves to 2 only after transfer.
REQ-034 res_ready=0 with continuous sources -> exactly 8 issues then pipe_in_valid=0, inflight=8; one result accepted -> next issue one cycle later.
REQ-035 drain_req=1 with 3 outstanding -> no new issue, drain_done rises one cycle after third result; drain_req=0 -> issue resumes next cycle.
REQ-036 pipe_out_valid forced with inflight=0 -> pipe_out_ready=1, res_valid=0, tag_err=1 and stays 1 until rst_n low.
REQ-037 rst_n low for 1 cycle with 5 outstanding -> inflight=0, all valid/ready outputs 0 immediately; after release, arbitration restarts at source 0.

Source files
------------

// File: rtl/tick_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tick_arbiter
// Purpose  : Round-robin arbiter sharing one in-order pipeline among NUM_SRC
//            tick sources; returns results tagged with their source index.
// Revision : 1.0  initial release
// ============================================================================
module tick_arbiter #(
    parameter  int NUM_SRC      = 4,
    parameter  int MAX_INFLIGHT = 8,
    localparam int IDW          = $clog2(NUM_SRC),
    localparam int CW           = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic [NUM_SRC-1:0][31:0] src_data,

    output logic                     pipe_in_valid,
    input  logic                     pipe_in_ready,
    output logic [31:0]              pipe_in_data,

    input  logic                     pipe_out_valid,
    output logic                     pipe_out_ready,
    input  logic [31:0]              pipe_out_data,

    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [IDW-1:0]           res_id,

    input  logic                     drain_req,
    output logic                     drain_done,
    output logic [CW-1:0]            inflight,
    output logic                     tag_err
);

    localparam int              PW       = $clog2(MAX_INFLIGHT);
    localparam logic [CW-1:0]   MAX_CNT  = CW'(MAX_INFLIGHT);
    localparam logic [IDW-1:0]  LAST_SRC = IDW'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [IDW-1:0] last;
    logic [IDW-1:0] lock_idx;
    logic           lock_held;
    logic [IDW-1:0] rr_winner;
    logic [IDW-1:0] rr_cand;
    logic           rr_found;
    logic [IDW-1:0] grant;

    logic           issue_en;
    logic           issue;
    logic           result;
    logic           fifo_empty;
    logic           orphan;

    logic [IDW-1:0] tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Round-robin search begins one past the last source that actually issued.
    always_comb begin
        rr_winner = last;
        rr_cand   = '0;
        rr_found  = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            rr_cand = IDW'((int'(last) + i) % NUM_SRC);
            if (!rr_found && src_valid[rr_cand]) begin
                rr_winner = rr_cand;
                rr_found  = 1'b1;
            end
        end
    end

    // A stalled offer keeps its source until it transfers.
    assign grant = lock_held ? lock_idx : rr_winner;

    // Outputs are gated by rst_n so every handshake is quiet while reset is low.
    assign issue_en      = rst_n && ((state == RUN) || lock_held) && (inflight < MAX_CNT);
    assign pipe_in_valid = src_valid[grant] && issue_en;
    assign pipe_in_data  = src_data[grant];
    assign issue         = pipe_in_valid && pipe_in_ready;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_ready
            assign src_ready[g] = (grant == IDW'(g)) && pipe_in_ready && issue_en;
        end
    endgenerate

    assign fifo_empty     = (inflight == '0);
    assign res_valid      = rst_n && pipe_out_valid && !fifo_empty;
    assign res_data       = pipe_out_data;
    assign res_id         = tag_mem[rd_ptr];
    assign pipe_out_ready = rst_n && (fifo_empty ? 1'b1 : res_ready);
    assign result         = res_valid && res_ready;
    assign orphan         = rst_n && pipe_out_valid && fifo_empty;

    assign drain_done     = (state == HALTED);

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (drain_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!drain_req)
                    state_nxt = RUN;
                else if (fifo_empty && !lock_held)
                    state_nxt = HALTED;
            end
            HALTED: begin
                if (!drain_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            last      <= LAST_SRC;
            lock_held <= 1'b0;
            lock_idx  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            inflight  <= '0;
            tag_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_held <= pipe_in_valid && !pipe_in_ready;
            if (pipe_in_valid && !pipe_in_ready)
                lock_idx <= grant;
            if (issue) begin
                last   <= grant;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (result)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({issue, result})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (orphan)
                tag_err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (issue)
            tag_mem[wr_ptr] <= grant;
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_arbiter.sv
`default_nettype none
// Directed bench for tick_arbiter with a two-cycle in-order pipeline model.
module tb_tick_arbiter;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       src_valid;
    logic [3:0]       src_ready;
    logic [3:0][31:0] src_data;
    logic             pipe_in_valid;
    logic             pipe_in_ready;
    logic [31:0]      pipe_in_data;
    logic             pipe_out_valid;
    logic             pipe_out_ready;
    logic [31:0]      pipe_out_data;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [1:0]       res_id;
    logic             drain_req;
    logic             drain_done;
    logic [3:0]       inflight;
    logic             tag_err;

    int errors = 0;
    int checks = 0;

    logic        use_model;
    logic        man_pov;
    logic [31:0] man_pod;
    logic [31:0] m_data [64];
    int          m_time [64];
    int          m_wr = 0;
    int          m_rd = 0;
    int          cyc  = 0;

    tick_arbiter #(.NUM_SRC(4), .MAX_INFLIGHT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .pipe_in_valid(pipe_in_valid), .pipe_in_ready(pipe_in_ready), .pipe_in_data(pipe_in_data),
        .pipe_out_valid(pipe_out_valid), .pipe_out_ready(pipe_out_ready), .pipe_out_data(pipe_out_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .drain_req(drain_req), .drain_done(drain_done), .inflight(inflight), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // Pipeline model: each sample emerges two cycles after issue, in order.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || !use_model) begin
            m_wr <= 0;
            m_rd <= 0;
        end else begin
            if (pipe_in_valid && pipe_in_ready) begin
                m_data[m_wr % 64] <= pipe_in_data;
                m_time[m_wr % 64] <= cyc;
                m_wr              <= m_wr + 1;
            end
            if (pipe_out_valid && pipe_out_ready)
                m_rd <= m_rd + 1;
        end
    end

    always_comb begin
        pipe_out_valid = man_pov;
        pipe_out_data  = man_pod;
        if (use_model) begin
            pipe_out_valid = (m_wr != m_rd) && (cyc >= m_time[m_rd % 64] + 2);
            pipe_out_data  = m_data[m_rd % 64];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        src_valid     = 4'h0;
        pipe_in_ready = 1'b0;
        res_ready     = 1'b0;
        drain_req     = 1'b0;
        use_model     = 1'b1;
        man_pov       = 1'b0;
        man_pod       = 32'h0;
        for (int i = 0; i < 4; i++) src_data[i] = 32'hA000_0000 + i;

        // Reset state with all inputs asking for activity
        repeat (3) tick();
        src_valid     = 4'hF;
        pipe_in_ready = 1'b1;
        res_ready     = 1'b1;
        #1;
        check("rst_src_ready",  {28'h0, src_ready}, 32'h0);
        check("rst_pin_valid",  {31'h0, pipe_in_valid}, 32'h0);
        check("rst_res_valid",  {31'h0, res_valid}, 32'h0);
        check("rst_inflight",   {28'h0, inflight}, 32'h0);
        check("rst_drain_done", {31'h0, drain_done}, 32'h0);
        check("rst_tag_err",    {31'h0, tag_err}, 32'h0);

        // Round-robin 0,1,2,3,... with depth-2 pipeline
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("rr_pin_valid", {31'h0, pipe_in_valid}, 32'h1);
            check("rr_pin_data",  pipe_in_data, 32'hA000_0000 + (k % 4));
            check("rr_src_ready", {28'h0, src_ready}, 32'h1 << (k % 4));
            check("rr_inflight",  {28'h0, inflight}, (k < 2) ? k : 2);
            if (k >= 2) begin
                check("rr_res_valid", {31'h0, res_valid}, 32'h1);
                check("rr_res_id",    {30'h0, res_id}, (k - 2) % 4);
                check("rr_res_data",  res_data, 32'hA000_0000 + ((k - 2) % 4));
            end else begin
                check("rr_res_idle", {31'h0, res_valid}, 32'h0);
            end
            tick();
        end
        src_valid = 4'h0;
        repeat (3) tick();
        check("rr_empty", {28'h0, inflight}, 32'h0);

        // Move last to source 0, then exercise the grant lock
        src_valid = 4'b0001;
        #1;
        check("pre_pin_valid", {31'h0, pipe_in_valid}, 32'h1);
        tick();
        src_valid = 4'h0;
        repeat (3) tick();
        check("pre_empty", {28'h0, inflight}, 32'h0);
        src_data[0]   = 32'h0001_8000;
        src_valid     = 4'b0001;
        pipe_in_ready = 1'b0;
        #1;
        check("lock_first_valid", {31'h0, pipe_in_valid}, 32'h1);
        check("lock_first_data",  pipe_in_data, 32'h0001_8000);
        tick();
        src_valid = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("lock_hold_data",  pipe_in_data, 32'h0001_8000);
            check("lock_hold_valid", {31'h0, pipe_in_valid}, 32'h1);
            check("lock_hold_ready", {28'h0, src_ready}, 32'h0);
            tick();
        end
        pipe_in_ready = 1'b1;
        #1;
        check("lock_xfer_ready", {28'h0, src_ready}, 32'b0001);
        check("lock_xfer_data",  pipe_in_data, 32'h0001_8000);
        tick();
        src_valid = 4'b0100;
        #1;
        check("lock_next_data",  pipe_in_data, 32'hA000_0002);
        check("lock_next_ready", {28'h0, src_ready}, 32'b0100);
        tick();
        src_valid   = 4'h0;
        src_data[0] = 32'hA000_0000;
        repeat (3) tick();
        check("lock_empty", {28'h0, inflight}, 32'h0);

        // Credit limit: res_ready low, exactly 8 issues
        res_ready = 1'b0;
        src_valid = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("cap_pin_valid", {31'h0, pipe_in_valid}, 32'h1);
            check("cap_inflight",  {28'h0, inflight}, k);
            tick();
        end
        check("cap_full_valid", {31'h0, pipe_in_valid}, 32'h0);
        check("cap_full_ready", {28'h0, src_ready}, 32'h0);
        check("cap_full_count", {28'h0, inflight}, 32'h8);
        res_ready = 1'b1;
        #1;
        check("cap_res_valid",     {31'h0, res_valid}, 32'h1);
        check("cap_res_id",        {30'h0, res_id}, 32'h3);
        check("cap_same_cycle_no", {31'h0, pipe_in_valid}, 32'h0);
        tick();
        res_ready = 1'b0;
        #1;
        check("cap_resume_valid", {31'h0, pipe_in_valid}, 32'h1);
        check("cap_resume_data",  pipe_in_data, 32'hA000_0003);
        check("cap_resume_count", {28'h0, inflight}, 32'h7);
        tick();
        check("cap_refull_valid", {31'h0, pipe_in_valid}, 32'h0);
        check("cap_refull_count", {28'h0, inflight}, 32'h8);
        src_valid = 4'h0;
        res_ready = 1'b1;
        repeat (10) tick();
        check("cap_empty", {28'h0, inflight}, 32'h0);

        // Drain with 3 outstanding
        res_ready = 1'b0;
        src_valid = 4'hF;
        repeat (3) tick();
        src_valid = 4'h0;
        drain_req = 1'b1;
        tick();
        src_valid = 4'hF;
        #1;
        check("drn_no_issue", {31'h0, pipe_in_valid}, 32'h0);
        check("drn_count3",   {28'h0, inflight}, 32'h3);
        check("drn_not_done", {31'h0, drain_done}, 32'h0);
        res_ready = 1'b1;
        for (int k = 2; k >= 0; k--) begin
            tick();
            check("drn_count",    {28'h0, inflight}, k);
            check("drn_wait",     {31'h0, drain_done}, 32'h0);
            check("drn_no_issue", {31'h0, pipe_in_valid}, 32'h0);
        end
        tick();
        check("drn_done", {31'h0, drain_done}, 32'h1);
        drain_req = 1'b0;
        #1;
        check("drn_halt_hold", {31'h0, pipe_in_valid}, 32'h0);
        tick();
        check("drn_resume_valid", {31'h0, pipe_in_valid}, 32'h1);
        check("drn_resume_data",  pipe_in_data, 32'hA000_0003);
        check("drn_done_clear",   {31'h0, drain_done}, 32'h0);
        src_valid = 4'h0;
        tick();
        check("drn_idle", {28'h0, inflight}, 32'h0);

        // Orphan result with nothing outstanding
        use_model = 1'b0;
        res_ready = 1'b0;
        man_pov   = 1'b1;
        man_pod   = 32'hDEAD_BEEF;
        #1;
        check("orph_pout_ready", {31'h0, pipe_out_ready}, 32'h1);
        check("orph_res_valid",  {31'h0, res_valid}, 32'h0);
        check("orph_err_before", {31'h0, tag_err}, 32'h0);
        tick();
        check("orph_err_set", {31'h0, tag_err}, 32'h1);
        man_pov = 1'b0;
        repeat (2) tick();
        check("orph_err_sticky", {31'h0, tag_err}, 32'h1);
        use_model = 1'b1;
        tick();

        // Reset mid-operation with 5 outstanding (last is 3 here)
        src_valid = 4'hF;
        repeat (5) tick();
        check("mrst_pre_count", {28'h0, inflight}, 32'h5);
        rst_n = 1'b0;
        #1;
        check("mrst_inflight",   {28'h0, inflight}, 32'h0);
        check("mrst_pin_valid",  {31'h0, pipe_in_valid}, 32'h0);
        check("mrst_src_ready",  {28'h0, src_ready}, 32'h0);
        check("mrst_res_valid",  {31'h0, res_valid}, 32'h0);
        check("mrst_pout_ready", {31'h0, pipe_out_ready}, 32'h0);
        check("mrst_tag_err",    {31'h0, tag_err}, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mrst_restart_valid", {31'h0, pipe_in_valid}, 32'h1);
        check("mrst_restart_data",  pipe_in_data, 32'hA000_0000);
        check("mrst_restart_ready", {28'h0, src_ready}, 32'b0001);
        src_valid = 4'h0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
